// File: rtl/addsub_serial.sv
// Slice-serial add/subtract unit for the calculator datapath.
// A WIDTH-bit add or subtract is processed SLICE bits per clock, with the carry
// held in a register between slices. Supports accumulate modes (ACC = result),
// optional signed saturation, a start/done handshake and registered flags.
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clear,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [WIDTH-1:0] SLMASK = WIDTH'({SLICE{1'b1}});

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state;
    logic [IDXW-1:0]          idx;
    logic                     carry;

    // Captured operands and the internal working register (never shown on result)
    logic signed [WIDTH-1:0]  opa_p0;
    logic signed [WIDTH-1:0]  opb_p0;
    logic signed [WIDTH-1:0]  work_p0;

    logic [SLICE-1:0]         a_sl;
    logic [SLICE-1:0]         b_sl;
    logic [SLICE:0]           sum;
    logic signed [WIDTH-1:0]  work_nx;
    logic signed [WIDTH-1:0]  fin_res;
    logic                     fin_ovf;
    logic                     last;
    logic                     accept;

    // Clamp to the signed limit on the side the first operand came from.
    function automatic logic signed [WIDTH-1:0] saturate(
        input logic signed [WIDTH-1:0] v,
        input logic                    o,
        input logic                    amsb
    );
        if (SAT && o)
            return amsb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return v;
    endfunction

    // Start is only honoured when no op is in flight and clear is not asserted
    assign accept = ((state == IDLE) || (state == DONE)) && start && !clear;
    assign last   = (idx == IDXW'(NSLICE - 1));

    // One slice of the ripple add, merged into the working value; the MSB-level
    // overflow test on the merged value is only meaningful on the last slice.
    always_comb begin
        int sh;
        sh      = int'(idx) * SLICE;
        a_sl    = SLICE'(opa_p0 >> sh);
        b_sl    = SLICE'(opb_p0 >> sh);
        sum     = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry};
        work_nx = (work_p0 & ~(SLMASK << sh)) | (WIDTH'(sum[SLICE-1:0]) << sh);
        fin_ovf = (opa_p0[WIDTH-1] == opb_p0[WIDTH-1]) &&
                  (work_nx[WIDTH-1] != opa_p0[WIDTH-1]);
        fin_res = saturate(work_nx, fin_ovf, opa_p0[WIDTH-1]);
    end

    // Operand capture at accepted start, slice write-back while running
    always_ff @(posedge clk) begin
        if (accept) begin
            opa_p0 <= op[1] ? result : a;
            opb_p0 <= b ^ {WIDTH{op[0]}};
        end else if (state == RUN) begin
            work_p0 <= work_nx;
        end
    end

    // Control FSM with registered handshake, result and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
            neg    <= 1'b0;
        end else if (clear) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
            neg    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        idx   <= '0;
                        carry <= op[0];
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    carry <= sum[SLICE];
                    idx   <= idx + IDXW'(1);
                    if (last) begin
                        result <= fin_res;
                        cout   <= sum[SLICE];
                        ovf    <= fin_ovf;
                        zero   <= (fin_res == '0);
                        neg    <= fin_res[WIDTH-1];
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial: 16/4 wrap and saturating instances share
// stimulus; an 8/8 instance covers the single-slice case and a random sweep.
module tb_addsub_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, clear;
    logic [1:0]  op;
    logic [15:0] a, b;

    logic        bz0, dn0, co0, ov0, zr0, ng0;
    logic [15:0] r0;
    logic        bz1, dn1, co1, ov1, zr1, ng1;
    logic [15:0] r1;

    logic        start2, clear2;
    logic [1:0]  op2;
    logic [7:0]  a2, b2;
    logic        bz2, dn2, co2, ov2, zr2, ng2;
    logic [7:0]  r2;

    int pass_cnt = 0;
    int total    = 0;

    addsub_serial #(.WIDTH(16), .SLICE(4), .SAT(1'b0)) d0 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .clear(clear),
        .busy(bz0), .done(dn0), .result(r0), .cout(co0), .ovf(ov0), .zero(zr0), .neg(ng0));

    addsub_serial #(.WIDTH(16), .SLICE(4), .SAT(1'b1)) d1 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .clear(clear),
        .busy(bz1), .done(dn1), .result(r1), .cout(co1), .ovf(ov1), .zero(zr1), .neg(ng1));

    addsub_serial #(.WIDTH(8), .SLICE(8), .SAT(1'b0)) d2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .op(op2), .a(a2), .b(b2), .clear(clear2),
        .busy(bz2), .done(dn2), .result(r2), .cout(co2), .ovf(ov2), .zero(zr2), .neg(ng2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    // Issue one op on the 16-bit pair; returns edges from start sample to done high.
    task automatic op16(input logic [1:0] o, input logic [15:0] aa, input logic [15:0] bb,
                        output int lat);
        op = o; a = aa; b = bb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!dn0 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op8(input logic [1:0] o, input logic [7:0] aa, input logic [7:0] bb,
                       output int lat);
        op2 = o; a2 = aa; b2 = bb; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        lat = 1;
        while (!dn2 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (dn0) cnt++;
        end
    endtask

    initial begin
        int lat, cnt;
        logic [7:0] acc, opa, opb, res;
        logic [8:0] full;
        logic [1:0] ro;
        logic [7:0] ra, rb;
        logic       mov;

        rst_n = 1'b0; start = 1'b0; clear = 1'b0; op = 2'b00; a = '0; b = '0;
        start2 = 1'b0; clear2 = 1'b0; op2 = 2'b00; a2 = '0; b2 = '0;
        #12;
        chk("reset_outputs", {bz0, dn0, co0, ov0, zr0, ng0, r0}, 32'h0);
        chk("reset_outputs8", {bz2, dn2, co2, ov2, zr2, ng2, r2}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // 1. plain add, latency and single done pulse
        op16(2'b00, 16'h1234, 16'h0FFF, lat);
        chk("t1_latency", lat, 5);
        chk("t1_result", r0, 16'h2233);
        chk("t1_flags_c_o_z_n", {co0, ov0, zr0, ng0}, 4'b0000);
        @(posedge clk); #1;
        chk("t1_done_one_cycle", dn0, 1'b0);

        // 2. subtract negative and zero results
        op16(2'b01, 16'h0005, 16'h0007, lat);
        chk("t2a_result", r0, 16'hFFFE);
        chk("t2a_flags_c_o_z_n", {co0, ov0, zr0, ng0}, 4'b0001);
        op16(2'b01, 16'h0007, 16'h0007, lat);
        chk("t2b_result", r0, 16'h0000);
        chk("t2b_flags_c_o_z_n", {co0, ov0, zr0, ng0}, 4'b1010);

        // 3. overflow, wrap versus saturate
        op16(2'b00, 16'h7FFF, 16'h0001, lat);
        chk("t3_wrap_result", r0, 16'h8000);
        chk("t3_wrap_flags_c_o_z_n", {co0, ov0, zr0, ng0}, 4'b0101);
        chk("t3_sat_result", r1, 16'h7FFF);
        chk("t3_sat_ovf", ov1, 1'b1);
        op16(2'b01, 16'h8000, 16'h0001, lat);
        chk("t3_satneg_result", r1, 16'h8000);
        chk("t3_satneg_ovf", ov1, 1'b1);

        // 4. accumulate chain, each start issued in the previous DONE cycle
        op16(2'b00, 16'h0000, 16'h0010, lat);
        op16(2'b10, 16'hAAAA, 16'h0010, lat);
        chk("t4_b2b_latency", lat, 5);
        op16(2'b10, 16'hAAAA, 16'h0010, lat);
        op16(2'b10, 16'hAAAA, 16'h0010, lat);
        chk("t4_acc_result", r0, 16'h0040);
        op16(2'b11, 16'h5555, 16'h0040, lat);
        chk("t4_accsub_result", r0, 16'h0000);
        chk("t4_accsub_flags_c_o_z_n", {co0, ov0, zr0, ng0}, 4'b1010);

        // 5a. start while busy is ignored
        @(negedge clk);
        op = 2'b00; a = 16'h0001; b = 16'h0002; start = 1'b1;
        @(posedge clk); #1;
        a = 16'h0100; b = 16'h0200; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 2;
        while (!dn0 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("t5a_latency", lat, 5);
        chk("t5a_result", r0, 16'h0003);
        count_done(10, cnt);
        chk("t5a_no_extra_done", cnt, 0);

        // 5b. clear at the second RUN edge drops the op
        op = 2'b00; a = 16'h0005; b = 16'h0005; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("t5b_cleared_outputs", {bz0, dn0, co0, ov0, zr0, ng0, r0}, 32'h0);
        count_done(8, cnt);
        chk("t5b_no_done", cnt, 0);

        // 5c. async reset mid-RUN
        op16(2'b00, 16'h0001, 16'h0002, lat);
        chk("t5c_pre_result", r0, 16'h0003);
        op = 2'b00; a = 16'h0100; b = 16'h0100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t5c_reset_outputs", {bz0, dn0, co0, ov0, zr0, ng0, r0}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        count_done(8, cnt);
        chk("t5c_no_done", cnt, 0);
        chk("t5c_result_held0", r0, 16'h0000);

        // 6. single-slice instance
        op8(2'b00, 8'h7F, 8'h01, lat);
        chk("t6_latency", lat, 2);
        chk("t6_result", r2, 8'h80);
        chk("t6_ovf", ov2, 1'b1);
        acc = 8'h80;
        for (int i = 0; i < 16; i++) begin
            ro = 2'(i % 4);
            ra = 8'($urandom);
            rb = 8'($urandom);
            opa  = ro[1] ? acc : ra;
            opb  = ro[0] ? ~rb : rb;
            full = {1'b0, opa} + {1'b0, opb} + {8'h00, ro[0]};
            res  = full[7:0];
            mov  = (opa[7] == opb[7]) && (res[7] != opa[7]);
            op8(ro, ra, rb, lat);
            chk($sformatf("t6_rand%0d_result", i), r2, res);
            chk($sformatf("t6_rand%0d_c_o_z_n", i), {co2, ov2, zr2, ng2},
                {full[8], mov, (res == 8'h00), res[7]});
            acc = res;
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
